// File: rtl/cfg_readback_tx_pkg.sv
// Shared types and constants for the configuration readback transmitter.
package cfg_readback_tx_pkg;

  localparam int unsigned DATA_W     = 35;
  localparam int unsigned DIV_W      = 8;
  localparam int unsigned KEY_MSB    = 34;
  localparam int unsigned KEY_LSB    = 33;
  localparam int unsigned FRAME_BITS = 38;
  localparam int unsigned IDX_W      = 6;
  localparam int unsigned LAST_IDX   = DATA_W - 1;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StCheck  = 3'd1,
    StStart  = 3'd2,
    StData   = 3'd3,
    StParity = 3'd4,
    StStop   = 3'd5,
    StDeny   = 3'd6
  } state_e;

  function automatic logic even_parity(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/cfg_readback_tx_if.sv
// Request/response bundle between a readback requester and the transmitter.
interface cfg_readback_tx_if;
  import cfg_readback_tx_pkg::*;

  logic              rd_req;
  logic [1:0]        rd_key;
  logic [DATA_W-1:0] mem_data;
  logic [DIV_W-1:0]  baud_div;
  logic              tx_dout;
  logic              busy;
  logic              done;
  logic              denied;
  logic [2:0]        dbg_state;

  modport master (
    output rd_req, rd_key, mem_data, baud_div,
    input  tx_dout, busy, done, denied, dbg_state
  );

  modport slave (
    input  rd_req, rd_key, mem_data, baud_div,
    output tx_dout, busy, done, denied, dbg_state
  );

endinterface

// File: rtl/cfg_readback_baud.sv
// Bit-period counter: counts 0..div_i while running and pulses bit_tick_o on the last cycle.
module cfg_readback_baud
  import cfg_readback_tx_pkg::*;
(
  input  logic             clk,
  input  logic             arst,
  input  logic [DIV_W-1:0] div_i,
  input  logic             run_i,
  output logic             bit_tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign bit_tick_o = run_i && (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (!run_i || bit_tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cfg_readback_tx.sv
// Snapshots the configuration word on an authorised request and sends it as a framed,
// even-parity serial stream: start, 35 data bits LSB first, parity, stop.
module cfg_readback_tx
  import cfg_readback_tx_pkg::*;
(
  input  logic               clk,
  input  logic               arst,
  cfg_readback_tx_if.slave   bus
);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              denied_q, denied_d;

  logic start_evt;
  logic run;
  logic bit_tick;

  assign start_evt = bus.rd_req & ~req_q;
  assign run       = (state_q == StStart) || (state_q == StData) ||
                     (state_q == StParity) || (state_q == StStop);

  cfg_readback_baud u_baud (
    .clk        (clk),
    .arst       (arst),
    .div_i      (div_q),
    .run_i      (run),
    .bit_tick_o (bit_tick)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= StIdle;
      req_q    <= 1'b1; // a request held high across reset must not start a frame
      shift_q  <= '0;
      parity_q <= 1'b0;
      div_q    <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      denied_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      denied_q <= denied_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = bus.rd_req;
    shift_d  = shift_q;
    parity_d = parity_q;
    div_d    = div_q;
    idx_d    = idx_q;
    case (state_q)
      StIdle: begin
        if (start_evt) state_d = StCheck;
      end
      StCheck: begin
        shift_d  = bus.mem_data;
        div_d    = bus.baud_div;
        parity_d = even_parity(bus.mem_data);
        idx_d    = '0;
        state_d  = (bus.rd_key == bus.mem_data[KEY_MSB:KEY_LSB]) ? StStart : StDeny;
      end
      StDeny: state_d = StIdle;
      StStart: begin
        if (bit_tick) state_d = StData;
      end
      StData: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_W'(LAST_IDX)) begin
            state_d = StParity;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      StParity: begin
        if (bit_tick) state_d = StStop;
      end
      StStop: begin
        if (bit_tick) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are derived from the next state so that the registered copies line up
  // with the state they describe.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d   = (state_d != StIdle);
    done_d   = (state_q == StStop) && bit_tick;
    denied_d = (state_d == StDeny);
  end

  assign bus.tx_dout   = tx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.denied    = denied_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_cfg_readback_tx.sv
// Self-checking bench for cfg_readback_tx against a per-cycle frame timeline model.
module tb_cfg_readback_tx;
  import cfg_readback_tx_pkg::*;

  logic clk;
  logic arst;
  int   n_cmp;
  int   n_err;

  cfg_readback_tx_if bus ();

  cfg_readback_tx dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] IdleVec = 7'b1000000;

  function automatic logic [6:0] observed();
    return {bus.tx_dout, bus.busy, bus.done, bus.denied, bus.dbg_state};
  endfunction

  // Expected {tx, busy, done, denied, state} in cycle k+n, k being the start-event cycle.
  function automatic logic [6:0] exp_vec(input logic [DATA_W-1:0] w, input logic [1:0] key,
                                         input int d, input int n);
    int         t;
    int         idx;
    logic       tx, bsy, dn, dny;
    logic [2:0] st;
    tx = 1'b1; bsy = 1'b0; dn = 1'b0; dny = 1'b0; st = 3'd0;
    t = n - 2;
    if (n == 1) begin
      bsy = 1'b1; st = 3'd1;
    end else if (n >= 2) begin
      if (key != w[34:33]) begin
        if (n == 2) begin
          bsy = 1'b1; dny = 1'b1; st = 3'd6;
        end
      end else if (t < int'(FRAME_BITS) * d) begin
        bsy = 1'b1;
        idx = t / d;
        if (idx == 0) begin
          tx = 1'b0; st = 3'd2;
        end else if (idx <= int'(DATA_W)) begin
          tx = w[idx-1]; st = 3'd3;
        end else if (idx == int'(DATA_W) + 1) begin
          tx = ^w; st = 3'd4;
        end else begin
          tx = 1'b1; st = 3'd5;
        end
      end else if (t == int'(FRAME_BITS) * d) begin
        dn = 1'b1;
      end
    end
    return {tx, bsy, dn, dny, st};
  endfunction

  function automatic logic [DATA_W-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DATA_W-1:0];
  endfunction

  task automatic test_reset();
    logic [6:0] obs;
    arst = 1'b1;
    bus.rd_req = 1'b1;
    bus.rd_key = 2'b00;
    bus.mem_data = '0;
    bus.baud_div = '0;
    #12;
    obs = observed();
    n_cmp++;
    if (obs !== IdleVec) begin
      n_err++;
      $display("FAIL reset_state got=%b want=%b", obs, IdleVec);
    end
    @(negedge clk);
    arst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      obs = observed();
      n_cmp++;
      if (obs !== IdleVec) begin
        n_err++;
        $display("FAIL reset_held_req cyc=%0d got=%b want=%b", i, obs, IdleVec);
      end
    end
    bus.rd_req = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_frame(input string name, input logic [DATA_W-1:0] word,
                            input logic [1:0] key, input logic [DIV_W-1:0] div,
                            input bit mutate);
    int         d;
    int         len;
    logic [6:0] obs, exp;
    d   = int'(div) + 1;
    len = (key == word[34:33]) ? int'(FRAME_BITS) * d + 4 : 6;
    repeat (2) @(posedge clk);
    #1;
    bus.mem_data = word;
    bus.rd_key   = key;
    bus.baud_div = div;
    bus.rd_req   = 1'b1;
    for (int n = 0; n < len; n++) begin
      @(negedge clk);
      obs = observed();
      exp = exp_vec(word, key, d, n);
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL %s cyc=%0d got=%b want=%b", name, n, obs, exp);
      end
      if (n == 1) bus.rd_req = 1'b0;
      if (mutate && n == 2 + 5 * d) begin
        bus.mem_data = rand_word();
        bus.baud_div = 8'($urandom_range(255, 0));
      end
    end
  endtask

  task automatic test_held_req();
    logic [DATA_W-1:0] w;
    logic [6:0]        obs, exp;
    int                n_done;
    w = rand_word();
    n_done = 0;
    @(posedge clk);
    #1;
    bus.mem_data = w;
    bus.rd_key   = w[34:33];
    bus.baud_div = '0;
    bus.rd_req   = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      obs = observed();
      exp = exp_vec(w, w[34:33], 1, n);
      n_done += int'(bus.done);
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL held_req cyc=%0d got=%b want=%b", n, obs, exp);
      end
      if (n == 10) bus.rd_req = 1'b0;
      if (n == 11) bus.rd_req = 1'b1;
    end
    n_cmp++;
    if (n_done !== 1) begin
      n_err++;
      $display("FAIL held_req_done_count got=%0d want=1", n_done);
    end
    bus.rd_req = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [DATA_W-1:0] w;
    logic [6:0]        obs, exp;
    w = rand_word();
    repeat (2) @(posedge clk);
    #1;
    bus.mem_data = w;
    bus.rd_key   = w[34:33];
    bus.baud_div = '0;
    bus.rd_req   = 1'b1;
    for (int n = 0; n <= 13; n++) begin
      @(negedge clk);
      obs = observed();
      exp = exp_vec(w, w[34:33], 1, n);
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL pre_abort cyc=%0d got=%b want=%b", n, obs, exp);
      end
    end
    #2;
    arst = 1'b1;
    #1;
    obs = observed();
    n_cmp++;
    if (obs !== IdleVec) begin
      n_err++;
      $display("FAIL async_abort got=%b want=%b", obs, IdleVec);
    end
    @(negedge clk);
    arst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      obs = observed();
      n_cmp++;
      if (obs !== IdleVec) begin
        n_err++;
        $display("FAIL post_abort_held cyc=%0d got=%b want=%b", i, obs, IdleVec);
      end
    end
    bus.rd_req = 1'b0;
    w = rand_word();
    test_frame("post_abort_frame", w, w[34:33], 8'd1, 1'b0);
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] w;
    logic [1:0]        key;
    for (int i = 0; i < 8; i++) begin
      w   = rand_word();
      key = ($urandom_range(1, 0) == 1) ? w[34:33] : 2'($urandom_range(3, 0));
      test_frame("random", w, key, 8'($urandom_range(2, 0)), 1'b0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.rd_req   = 1'b0;
    bus.rd_key   = 2'b00;
    bus.mem_data = '0;
    bus.baud_div = '0;
    arst = 1'b1;
    test_reset();
    test_frame("key_match", 35'h5_1234_5678, 2'b10, 8'd0, 1'b0);
    test_frame("key_deny", 35'h5_1234_5678, 2'b01, 8'd0, 1'b0);
    test_frame("div3_mutate", 35'h5_1234_5678, 2'b10, 8'd3, 1'b1);
    test_held_req();
    test_async_reset();
    test_frame("parity_zero", 35'h0_0000_0000, 2'b00, 8'd0, 1'b0);
    test_frame("parity_ones", 35'h7_FFFF_FFFF, 2'b11, 8'd0, 1'b0);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
